shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that sequences the single-position `shifter` datapath to perform shifts and rotates of 0 to DSIZE-1 positions. A requester hands over an operand, an operation and a shift amount through a start/ready handshake. The block holds the operand in a working register and drives the shifter once per clock, feeding each result back, until the amount is exhausted. It then presents the result with a one-cycle `done` pulse. It sits between the control unit and the shifter and owns the shifter's inputs exclusively.

## Interface
- `OPSIZE`, 2, operation code width; encoding is the shifter's: 00 SRL, 01 SLL, 10 ROR, 11 ROL.
- `DSIZE`, 16, data width.
- `ASIZE`, 4, shift-amount width; must satisfy 2^ASIZE ≥ DSIZE.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `op`  in  OPSIZE  operation for the request.
- `amount`  in  ASIZE  number of 1-position steps.
- `data_in`  in  DSIZE  operand.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  DSIZE  working register; holds its value until the next acceptance.
- `sh_data_b`  out  DSIZE  to `shifter.data_b`; equals the working register.
- `sh_op`  out  OPSIZE  to `shifter.op`; equals the latched op.
- `sh_f`  in  DSIZE  from `shifter.f`; combinational result.

## Operation
- **State machine:** IDLE, SHIFT, DONE. All outputs are decoded from the state and the registers; there are no combinational paths from inputs to outputs.
- **IDLE:** `ready`=1. If `start`=1 at an edge, the block latches `work<=data_in`, `op_r<=op` and `cnt<=amount`.
  - If `amount`==0, the next state is DONE.
  - Otherwise the next state is SHIFT.
- **SHIFT:** at each edge, `work<=sh_f` and `cnt<=cnt-1`.
  - When `cnt`==1 at the edge, the next state is DONE.
- **DONE:** `done`=1 for exactly one cycle. The next state is IDLE unconditionally.
- `start` in SHIFT or DONE is ignored; there is no queueing. `op`, `amount` and `data_in` are sampled only at the acceptance edge.
- **Amount wrap rules:** `amount` ≥ DSIZE (only possible when 2^ASIZE > DSIZE) is executed literally.
  - SRL/SLL then yield 0.
  - Rotates wrap modulo DSIZE naturally.
- `sh_data_b`/`sh_op` are driven in every state. The shifter output is consumed only in SHIFT.

## Timing
- **Reset values:** state IDLE, `work`=0, `op_r`=0, `cnt`=0. This gives `ready`=1, `busy`=0, `done`=0, `result`=0, `sh_data_b`=0, `sh_op`=0.
- **Reset mid-operation:** immediate return to the reset values. The operation is lost; no `done` is produced. The block can accept a request at the first edge after `rst_n` deasserts.
- **Latency:** let acceptance edge = E0. `done` is high in the cycle after edge E(amount), i.e. amount+1 cycles after `start` is sampled.
  - `amount`=0: `done` in the cycle after E0.
  - `ready` returns 1 in the cycle after `done`.
- **Throughput:** one request per amount+2 cycles. Back-to-back `start` held high is accepted on the first IDLE edge.

## Configuration
- **Macro:** `SHIFT_SEQ_EARLY_EXIT_EN`.
- **Defined:** in SHIFT, if `op_r[1]`==0 (logical shift) and `sh_f`==0, then at that edge `work<=0` and the next state is DONE regardless of `cnt`. Rotates are unaffected. Latency becomes min(amount, k) edges, where k is the step at which the value first becomes zero.
- **Undefined:** SHIFT always runs exactly `amount` steps. Results are identical in both builds; only latency differs.

## Test plan
- **Reset:** hold `rst_n`=0 → `ready`=1, `busy`=0, `done`=0, `result`=0x0000.
- **ROL:** `data_in`=0x8001, `op`=11, `amount`=1 → `done` 2 cycles after `start`, `result`=0x0003.
- **SRL:** `data_in`=0xF000, `op`=00, `amount`=4 → `busy` for 4 cycles, `done` 5 cycles after `start`, `result`=0x0F00; `start` pulses during SHIFT are ignored.
- **ROR:** `data_in`=0x0001, `op`=10, `amount`=15 → `result`=0x0002, `done` 16 cycles after `start`. Then `amount`=0 with `data_in`=0xA5A5 → `result`=0xA5A5, `done` 1 cycle after `start`.
- **Early exit:** `data_in`=0x0100, `op`=01, `amount`=12 → `result`=0x0000. `done` 9 cycles after `start` with `SHIFT_SEQ_EARLY_EXIT_EN`, 13 cycles without.
- **Reset mid-operation:** pulse `rst_n` low during SHIFT of a 10-step SLL → no `done`, `result`=0, `ready`=1. A fresh request afterwards completes correctly.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle controller driving a single-position shifter.
//               Latches an operand/op/amount on a start/ready handshake,
//               feeds the shifter output back once per clock until the
//               amount is used up, then pulses done with the result.
//               Optional build macro SHIFT_SEQ_EARLY_EXIT_EN: logical
//               shifts finish as soon as the working value becomes zero.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int OPSIZE = 2,
  parameter int DSIZE  = 16,
  parameter int ASIZE  = 4    // 2**ASIZE must be >= DSIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPSIZE-1:0] op,
  input  logic [ASIZE-1:0]  amount,
  input  logic [DSIZE-1:0]  data_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DSIZE-1:0]  result,
  output logic [DSIZE-1:0]  sh_data_b,
  output logic [OPSIZE-1:0] sh_op,
  input  logic [DSIZE-1:0]  sh_f
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ASIZE-1:0] C_CNT_ONE = ASIZE'(1);

  state_t             state;
  logic [DSIZE-1:0]   work;
  logic [OPSIZE-1:0]  op_r;
  logic [ASIZE-1:0]   cnt;

  // Exit condition evaluated in SHIFT: count exhausted, or (optionally) a
  // logical shift that has already cleared every bit.
  logic               last_step;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic               zero_exit;

  // Only logical shifts (op_r[1]==0) can collapse to zero; rotates never do.
  always_comb begin
    zero_exit = (op_r[1] == 1'b0) && (sh_f == '0);
    last_step = (cnt == C_CNT_ONE) || zero_exit;
  end
`else
  // Plain build: always run the full requested number of steps.
  always_comb begin
    last_step = (cnt == C_CNT_ONE);
  end
`endif

  // Sequencer state, working register, latched op and remaining-step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      work  <= '0;
      op_r  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= data_in;
            op_r  <= op;
            cnt   <= amount;
            state <= (amount == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          // In the early-exit case sh_f is already zero, so loading it is
          // the same as clearing the working register.
          work <= sh_f;
          cnt  <= cnt - C_CNT_ONE;
          if (last_step) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only from registered state, no input-to-output paths.
  assign ready     = (state == S_IDLE);
  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign result    = work;
  assign sh_data_b = work;
  assign sh_op     = op_r;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed, table-driven bench for shift_sequencer with a
//               behavioural single-position shifter on the sh_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  localparam int OPSIZE = 2;
  localparam int DSIZE  = 16;
  localparam int ASIZE  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [OPSIZE-1:0] op;
  logic [ASIZE-1:0]  amount;
  logic [DSIZE-1:0]  data_in;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DSIZE-1:0]  result;
  logic [DSIZE-1:0]  sh_data_b;
  logic [OPSIZE-1:0] sh_op;
  logic [DSIZE-1:0]  sh_f;

  int n_checks;
  int n_fail;

  shift_sequencer #(
    .OPSIZE(OPSIZE),
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .sh_data_b(sh_data_b),
    .sh_op    (sh_op),
    .sh_f     (sh_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference single-position shifter: 00 SRL, 01 SLL, 10 ROR, 11 ROL.
  always_comb begin
    case (sh_op)
      2'b00:   sh_f = {1'b0, sh_data_b[DSIZE-1:1]};
      2'b01:   sh_f = {sh_data_b[DSIZE-2:0], 1'b0};
      2'b10:   sh_f = {sh_data_b[0], sh_data_b[DSIZE-1:1]};
      default: sh_f = {sh_data_b[DSIZE-2:0], sh_data_b[DSIZE-1]};
    endcase
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] data;
    logic [15:0] exp_result;
    int          lat_norm;   // edges from acceptance to done, full run
    int          lat_ee;     // same, with early exit on logical zero
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one request and follow it to done. If pulse_mid is set, a
  // conflicting start is asserted for one cycle while the block is busy.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [3:0] a, input logic [15:0] d,
                        input logic [15:0] exp_res, input int exp_lat,
                        input bit pulse_mid);
    int n;
    int busy_cnt;
    @(negedge clk);
    check({name, " ready before start"}, {31'd0, ready}, 32'd1);
    start   = 1'b1;
    op      = o;
    amount  = a;
    data_in = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (pulse_mid && n == 2) begin
        start   = 1'b1;
        op      = 2'b01;
        amount  = 4'd1;
        data_in = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check({name, " done seen"}, {31'd0, done}, 32'd1);
    check({name, " latency"}, n, exp_lat);
    check({name, " busy cycles"}, busy_cnt, exp_lat - 1);
    check({name, " result"}, {16'd0, result}, {16'd0, exp_res});
    check({name, " ready low in done"}, {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, {31'd0, done}, 32'd0);
    check({name, " ready after done"}, {31'd0, ready}, 32'd1);
    check({name, " result held"}, {16'd0, result}, {16'd0, exp_res});
  endtask

  initial begin
    int lat;
    logic [7:0] pattern;
    n_checks = 0;
    n_fail   = 0;

    //            name        op     amt    data      result    norm ee
    vecs[0] = '{"rol1",      2'b11, 4'd1,  16'h8001, 16'h0003, 2,  2};
    vecs[1] = '{"srl4",      2'b00, 4'd4,  16'hF000, 16'h0F00, 5,  5};
    vecs[2] = '{"ror15",     2'b10, 4'd15, 16'h0001, 16'h0002, 16, 16};
    vecs[3] = '{"amt0",      2'b01, 4'd0,  16'hA5A5, 16'hA5A5, 1,  1};
    vecs[4] = '{"sll12",     2'b01, 4'd12, 16'h0100, 16'h0000, 13, 9};
    vecs[5] = '{"sll4",      2'b01, 4'd4,  16'h1234, 16'h2340, 5,  5};
    vecs[6] = '{"rol4",      2'b11, 4'd4,  16'hABCD, 16'hBCDA, 5,  5};
    vecs[7] = '{"srl15",     2'b00, 4'd15, 16'h8000, 16'h0001, 16, 16};
    vecs[8] = '{"srl3zero",  2'b00, 4'd3,  16'h0003, 16'h0000, 4,  3};
    vecs[9] = '{"ror8",      2'b10, 4'd8,  16'h1234, 16'h3412, 9,  9};

    rst_n   = 1'b0;
    start   = 1'b0;
    op      = '0;
    amount  = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", {16'd0, result}, 32'd0);
    check("reset sh_data_b", {16'd0, sh_data_b}, 32'd0);
    check("reset sh_op", {30'd0, sh_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single requests.
    for (int i = 0; i < NVEC; i++) begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      lat = vecs[i].lat_ee;
`else
      lat = vecs[i].lat_norm;
`endif
      run_op(vecs[i].name, vecs[i].op, vecs[i].amount, vecs[i].data,
             vecs[i].exp_result, lat, 1'b0);
    end

    // start pulse during SHIFT must be ignored.
    run_op("srl4 pulse", 2'b00, 4'd4, 16'hF000, 16'h0F00, 5, 1'b1);

    // sh_* follow the working register and latched op while busy.
    @(negedge clk);
    start = 1'b1; op = 2'b10; amount = 4'd3; data_in = 16'h00F0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("sh_op latched", {30'd0, sh_op}, 32'd2);
    check("sh_data_b step0", {16'd0, sh_data_b}, 32'h00F0);
    @(posedge clk);
    #1;
    check("sh_data_b step1", {16'd0, sh_data_b}, 32'h0078);
    repeat (4) @(posedge clk);
    #1;
    check("ror3 result", {16'd0, result}, 32'h001E);

    // start held high: accepted on every IDLE edge, period amount+2.
    @(negedge clk);
    check("b2b ready", {31'd0, ready}, 32'd1);
    start = 1'b1; op = 2'b11; amount = 4'd1; data_in = 16'h0001;
    @(posedge clk);
    pattern = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      pattern[k] = done;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    check("b2b done pattern", {24'd0, pattern}, 32'h0000_0092);
    check("b2b result", {16'd0, result}, 32'h0002);
    repeat (4) @(posedge clk);

    // Reset in the middle of a 10-step SLL.
    @(negedge clk);
    start = 1'b1; op = 2'b01; amount = 4'd10; data_in = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst busy before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst ready", {31'd0, ready}, 32'd1);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pattern = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      pattern[k] = done;
    end
    check("midrst no done", {24'd0, pattern}, 32'd0);
    run_op("post reset sll3", 2'b01, 4'd3, 16'h0101, 16'h0808, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
